// File: rtl/bin2bcd_pkg.sv
// Shared constants, FSM state type and the leading-zero helper for the binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam int NUM_DIGITS = 6;
    localparam int unsigned MAX_VAL = 10**NUM_DIGITS - 1;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Units digit is always shown, so bit 0 is forced clear after the scan.
    function automatic logic [NUM_DIGITS-1:0] calc_blank(input logic [DIGIT_W*NUM_DIGITS-1:0] d);
        logic seen;
        seen = 1'b0;
        calc_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            seen = seen | (d[i*DIGIT_W +: DIGIT_W] != '0);
            calc_blank[i] = ~seen;
        end
        calc_blank[0] = 1'b0;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Purpose: one shift-and-add-3 correction cell; a digit >= 5 gets +3 before the shift.
// Latency: combinational.
// Backpressure: none.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Purpose: sequential binary to six-digit BCD with leading-zero blank mask and overflow flag.
// Latency: done pulses BIN_W+1 edges after the start edge; back-to-back period BIN_W+2.
// Backpressure: start is taken only in IDLE; starts while busy are dropped, not queued.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BIN_W-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [DIGIT_W*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]         blank,
    output logic                          ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SCR_W = DIGIT_W * NUM_DIGITS;
    localparam logic [NUM_DIGITS-1:0] BLANK_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

    state_t           state;
    logic [SCR_W-1:0] scratch;
    logic [SCR_W-1:0] adj;
    logic [SCR_W-1:0] result;
    logic [BIN_W-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             ovf_next;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d(scratch[g*DIGIT_W +: DIGIT_W]),
            .q(adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Out-of-range inputs saturate the display to all nines.
    assign result = ovf_next ? {NUM_DIGITS{4'h9}} : scratch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            blank    <= BLANK_RST;
            ovf      <= 1'b0;
            scratch  <= '0;
            sreg     <= '0;
            cnt      <= '0;
            ovf_next <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sreg     <= bin_in;
                        scratch  <= '0;
                        cnt      <= CNT_W'(BIN_W);
                        ovf_next <= (32'(bin_in) > MAX_VAL);
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Top scratch bit falls off the end; overflow comes from ovf_next only.
                    scratch <= SCR_W'({adj, sreg[BIN_W-1]});
                    sreg    <= {sreg[BIN_W-2:0], 1'b0};
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    bcd_out <= result;
                    blank   <= calc_blank(result);
                    ovf     <= ovf_next;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq with a queue of expected conversion results.
module tb_bin2bcd_seq;
    import bin2bcd_pkg::*;

    localparam int BIN_W = 20;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          start;
    logic [BIN_W-1:0]              bin_in;
    logic                          busy;
    logic                          done;
    logic [DIGIT_W*NUM_DIGITS-1:0] bcd_out;
    logic [NUM_DIGITS-1:0]         blank;
    logic                          ovf;

    typedef struct packed {
        logic [23:0] bcd;
        logic [5:0]  blank;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bin2bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .bcd_out(bcd_out),
        .blank  (blank),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        int unsigned tmp;
        int          nd;
        e = '0;
        if (v > 999999) begin
            e.bcd   = 24'h999999;
            e.blank = 6'b000000;
            e.ovf   = 1'b1;
        end else begin
            tmp = v;
            for (int i = 0; i < 6; i++) begin
                e.bcd[4*i +: 4] = 4'(tmp % 10);
                tmp = tmp / 10;
            end
            nd  = 1;
            tmp = v;
            while (tmp >= 10) begin
                tmp = tmp / 10;
                nd++;
            end
            for (int i = 0; i < 6; i++) e.blank[i] = (i >= nd);
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_bcd"},   32'(bcd_out), 32'h0);
        check({tag, "_blank"}, 32'(blank),   32'b111110);
        check({tag, "_ovf"},   32'(ovf),     32'h0);
        check({tag, "_busy"},  32'(busy),    32'h0);
        check({tag, "_done"},  32'(done),    32'h0);
    endtask

    task automatic start_conv(input int unsigned v);
        bin_in = v[BIN_W-1:0];
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
        check("busy_after_start", 32'(busy), 32'h1);
        check("done_clear_after_start", 32'(done), 32'h0);
    endtask

    task automatic finish_conv(input int exp_lat);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        check("done_seen", 32'(done), 32'h1);
        if (done) begin
            check("latency", 32'(cyc), 32'(exp_lat));
            check("sb_nonempty", 32'(sb.size() > 0), 32'h1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("bcd_out", 32'(bcd_out), 32'(e.bcd));
                check("blank",   32'(blank),   32'(e.blank));
                check("ovf",     32'(ovf),     32'(e.ovf));
            end
        end
    endtask

    task automatic count_dones(input int n, output int nd);
        nd = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done) nd++;
        end
    endtask

    initial begin
        int           nd;
        int unsigned  vals [6];

        rst    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_vals("reset");

        // single conversion, then hold
        sb.push_back(model(123456));
        start_conv(123456);
        finish_conv(21);
        tick();
        check("busy_after_done", 32'(busy), 32'h0);
        check("done_one_cycle", 32'(done), 32'h0);
        check("hold_bcd", 32'(bcd_out), 32'h123456);

        // back-to-back, including overflow saturation and recovery
        vals = '{0, 7, 999999, 1000000, 1048575, 42};
        for (int i = 0; i < 6; i++) begin
            sb.push_back(model(vals[i]));
            start_conv(vals[i]);
            finish_conv(21);
        end

        // start pulse mid-conversion must be ignored
        tick();
        sb.push_back(model(555));
        start_conv(555);
        repeat (4) tick();
        bin_in = 20'd888;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        finish_conv(16);
        count_dones(30, nd);
        check("no_extra_done", 32'(nd), 32'h0);
        check("hold_555", 32'(bcd_out), 32'h000555);

        // reset mid-conversion
        start_conv(654321);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("midreset");
        count_dones(30, nd);
        check("no_done_after_reset", 32'(nd), 32'h0);

        sb.push_back(model(31));
        start_conv(31);
        finish_conv(21);

        check("sb_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
